// File: rtl/gact_tb_arbiter_pkg.sv
// Shared types for the traceback arbiter: FSM state encoding and 2-bit direction codes.
package gact_tb_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GRANT  = 3'd1,
        ST_START  = 3'd2,
        ST_RUN    = 3'd3,
        ST_FLUSH  = 3'd4,
        ST_REPORT = 3'd5
    } state_t;

    localparam logic [1:0] DIR_ZERO = 2'd0;
    localparam logic [1:0] DIR_V    = 2'd1;
    localparam logic [1:0] DIR_H    = 2'd2;
    localparam logic [1:0] DIR_M    = 2'd3;

endpackage

// File: rtl/gact_tb_arbiter_tb_dir_packer.sv
// Packs 2-bit traceback directions into words, first direction in the low bits.
// Writes are registered; a partial word is flushed with zero padding when done arrives.
module gact_tb_arbiter_tb_dir_packer
    import gact_tb_arbiter_pkg::*;
#(
    parameter int TB_WORD_WIDTH = 32,
    parameter int WADDR_WIDTH   = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic [1:0]               dir,
    input  logic                     dir_valid,
    input  logic                     done,
    output logic                     wr_en,
    output logic [WADDR_WIDTH-1:0]   wr_addr,
    output logic [TB_WORD_WIDTH-1:0] wr_data,
    output logic [WADDR_WIDTH:0]     num_words
);

    localparam int DPW = TB_WORD_WIDTH / 2;
    localparam int CW  = (DPW > 1) ? $clog2(DPW) : 1;

    logic [CW-1:0]            cnt;
    logic [CW-1:0]            cnt_after;
    logic [TB_WORD_WIDTH-1:0] acc;
    logic [TB_WORD_WIDTH-1:0] acc_next;
    logic [WADDR_WIDTH-1:0]   waddr;
    logic                     last;
    logic                     do_write;

    // A direction arriving with done is packed first, so the flush decision uses cnt_after.
    always_comb begin
        acc_next  = acc;
        last      = 1'b0;
        cnt_after = cnt;
        if (dir_valid) begin
            acc_next[{cnt, 1'b0} +: 2] = dir;
            if (cnt == CW'(DPW - 1)) begin
                last      = 1'b1;
                cnt_after = '0;
            end else begin
                cnt_after = cnt + 1'b1;
            end
        end
        do_write = last || (done && (cnt_after != '0));
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt       <= '0;
            acc       <= {DPW{DIR_ZERO}};
            waddr     <= '0;
            num_words <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            wr_en <= do_write;
            if (do_write) begin
                wr_data   <= acc_next;
                wr_addr   <= waddr;
                waddr     <= waddr + 1'b1;
                num_words <= num_words + 1'b1;
                acc       <= {DPW{DIR_ZERO}};
                cnt       <= '0;
            end else begin
                acc <= acc_next;
                cnt <= cnt_after;
            end
        end
    end

endmodule

// File: rtl/gact_tb_arbiter.sv
// Round-robin arbiter sharing one traceback engine among NUM_REQ arrays; latches job
// parameters, starts the engine, packs its directions into SRAM words and reports results.
module gact_tb_arbiter
    import gact_tb_arbiter_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int LOG_NUM_REQ   = 2,
    parameter int ADDR_WIDTH    = 20,
    parameter int REF_LEN_WIDTH = 12,
    parameter int LOG_NUM_PE    = 6,
    parameter int TB_WORD_WIDTH = 32,
    parameter int WADDR_WIDTH   = 10
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req,
    output logic [NUM_REQ-1:0]               gnt,
    input  logic [REF_LEN_WIDTH-1:0]         p_ref_length,
    input  logic [ADDR_WIDTH-1:0]            p_max_mod_addr,
    input  logic [ADDR_WIDTH-1:0]            p_max_addr,
    input  logic [LOG_NUM_PE-1:0]            p_max_pe,
    input  logic [1:0]                       p_max_pe_state,
    input  logic [REF_LEN_WIDTH-1:0]         p_max_H_offset,
    input  logic [REF_LEN_WIDTH-1:0]         p_max_V_offset,
    output logic                             bt_start,
    output logic [REF_LEN_WIDTH-1:0]         bt_ref_length,
    output logic [ADDR_WIDTH-1:0]            bt_max_score_mod_addr,
    output logic [ADDR_WIDTH-1:0]            bt_max_score_addr,
    output logic [LOG_NUM_PE-1:0]            bt_max_score_pe,
    output logic [1:0]                       bt_max_score_pe_state,
    output logic [REF_LEN_WIDTH-1:0]         bt_max_H_offset,
    output logic [REF_LEN_WIDTH-1:0]         bt_max_V_offset,
    input  logic [1:0]                       bt_dir,
    input  logic                             bt_dir_valid,
    input  logic                             bt_done,
    input  logic [REF_LEN_WIDTH-1:0]         bt_H_offset,
    input  logic [REF_LEN_WIDTH-1:0]         bt_V_offset,
    input  logic [ADDR_WIDTH+LOG_NUM_PE-1:0] bt_num_tb_steps,
    output logic                             tb_wr_en,
    output logic [WADDR_WIDTH-1:0]           tb_wr_addr,
    output logic [TB_WORD_WIDTH-1:0]         tb_wr_data,
    output logic [LOG_NUM_REQ-1:0]           tb_wr_id,
    output logic                             res_valid,
    output logic [LOG_NUM_REQ-1:0]           res_id,
    output logic [REF_LEN_WIDTH-1:0]         res_H_offset,
    output logic [REF_LEN_WIDTH-1:0]         res_V_offset,
    output logic [ADDR_WIDTH+LOG_NUM_PE-1:0] res_num_tb_steps,
    output logic [WADDR_WIDTH:0]             res_num_words
);

    state_t                 state;
    state_t                 state_nxt;
    logic [LOG_NUM_REQ-1:0] cur_id;
    logic [LOG_NUM_REQ-1:0] rr_ptr;
    logic [LOG_NUM_REQ-1:0] pick_id;
    logic [LOG_NUM_REQ-1:0] cand;
    logic                   pick_vld;
    logic                   in_run;

    assign in_run = (state == ST_RUN);

    // Scan downward so the candidate closest to rr_ptr is the last one assigned.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        cand     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = LOG_NUM_REQ'((int'(rr_ptr) + i) % NUM_REQ);
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick_id  = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (pick_vld) state_nxt = ST_GRANT;
            ST_GRANT:  state_nxt = ST_START;
            ST_START:  state_nxt = ST_RUN;
            ST_RUN:    if (bt_done) state_nxt = ST_FLUSH;
            ST_FLUSH:  state_nxt = ST_REPORT;
            ST_REPORT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt = '0;
        if (state == ST_GRANT) gnt[cur_id] = 1'b1;
        bt_start  = (state == ST_START);
        res_valid = (state == ST_REPORT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_id                <= '0;
            rr_ptr                <= '0;
            bt_ref_length         <= '0;
            bt_max_score_mod_addr <= '0;
            bt_max_score_addr     <= '0;
            bt_max_score_pe       <= '0;
            bt_max_score_pe_state <= '0;
            bt_max_H_offset       <= '0;
            bt_max_V_offset       <= '0;
            res_H_offset          <= '0;
            res_V_offset          <= '0;
            res_num_tb_steps      <= '0;
        end else begin
            if (state == ST_IDLE && pick_vld) cur_id <= pick_id;
            if (state == ST_GRANT) begin
                bt_ref_length         <= p_ref_length;
                bt_max_score_mod_addr <= p_max_mod_addr;
                bt_max_score_addr     <= p_max_addr;
                bt_max_score_pe       <= p_max_pe;
                bt_max_score_pe_state <= p_max_pe_state;
                bt_max_H_offset       <= p_max_H_offset;
                bt_max_V_offset       <= p_max_V_offset;
            end
            if (in_run && bt_done) begin
                res_H_offset     <= bt_H_offset;
                res_V_offset     <= bt_V_offset;
                res_num_tb_steps <= bt_num_tb_steps;
            end
            if (state == ST_REPORT) rr_ptr <= LOG_NUM_REQ'((int'(cur_id) + 1) % NUM_REQ);
        end
    end

    assign res_id   = cur_id;
    assign tb_wr_id = cur_id;

    gact_tb_arbiter_tb_dir_packer #(
        .TB_WORD_WIDTH (TB_WORD_WIDTH),
        .WADDR_WIDTH   (WADDR_WIDTH)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (state == ST_START),
        .dir       (bt_dir),
        .dir_valid (in_run && bt_dir_valid),
        .done      (in_run && bt_done),
        .wr_en     (tb_wr_en),
        .wr_addr   (tb_wr_addr),
        .wr_data   (tb_wr_data),
        .num_words (res_num_words)
    );

endmodule

// File: tb/tb_gact_tb_arbiter.sv
// Directed bench for gact_tb_arbiter: grant timing, packing, flush, round-robin, reset abort.
module tb_gact_tb_arbiter;
    import gact_tb_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [3:0]  gnt;
    logic [11:0] p_ref_length = 12'h123;
    logic [19:0] p_max_mod_addr = 20'h0_0AB1;
    logic [19:0] p_max_addr = 20'h4_5678;
    logic [5:0]  p_max_pe = 6'd37;
    logic [1:0]  p_max_pe_state = 2'd2;
    logic [11:0] p_max_H_offset = 12'h0AB;
    logic [11:0] p_max_V_offset = 12'h0CD;
    logic        bt_start;
    logic [11:0] bt_ref_length;
    logic [19:0] bt_max_score_mod_addr;
    logic [19:0] bt_max_score_addr;
    logic [5:0]  bt_max_score_pe;
    logic [1:0]  bt_max_score_pe_state;
    logic [11:0] bt_max_H_offset;
    logic [11:0] bt_max_V_offset;
    logic [1:0]  bt_dir = '0;
    logic        bt_dir_valid = 1'b0;
    logic        bt_done = 1'b0;
    logic [11:0] bt_H_offset = 12'h055;
    logic [11:0] bt_V_offset = 12'h066;
    logic [25:0] bt_num_tb_steps = 26'd5;
    logic        tb_wr_en;
    logic [9:0]  tb_wr_addr;
    logic [31:0] tb_wr_data;
    logic [1:0]  tb_wr_id;
    logic        res_valid;
    logic [1:0]  res_id;
    logic [11:0] res_H_offset;
    logic [11:0] res_V_offset;
    logic [25:0] res_num_tb_steps;
    logic [10:0] res_num_words;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    gact_tb_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt),
        .p_ref_length(p_ref_length), .p_max_mod_addr(p_max_mod_addr), .p_max_addr(p_max_addr),
        .p_max_pe(p_max_pe), .p_max_pe_state(p_max_pe_state),
        .p_max_H_offset(p_max_H_offset), .p_max_V_offset(p_max_V_offset),
        .bt_start(bt_start), .bt_ref_length(bt_ref_length),
        .bt_max_score_mod_addr(bt_max_score_mod_addr), .bt_max_score_addr(bt_max_score_addr),
        .bt_max_score_pe(bt_max_score_pe), .bt_max_score_pe_state(bt_max_score_pe_state),
        .bt_max_H_offset(bt_max_H_offset), .bt_max_V_offset(bt_max_V_offset),
        .bt_dir(bt_dir), .bt_dir_valid(bt_dir_valid), .bt_done(bt_done),
        .bt_H_offset(bt_H_offset), .bt_V_offset(bt_V_offset), .bt_num_tb_steps(bt_num_tb_steps),
        .tb_wr_en(tb_wr_en), .tb_wr_addr(tb_wr_addr), .tb_wr_data(tb_wr_data), .tb_wr_id(tb_wr_id),
        .res_valid(res_valid), .res_id(res_id), .res_H_offset(res_H_offset),
        .res_V_offset(res_V_offset), .res_num_tb_steps(res_num_tb_steps),
        .res_num_words(res_num_words)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write and result capture, sampled on the falling edge.
    logic [31:0] wq_data[$];
    logic [9:0]  wq_addr[$];
    logic [1:0]  wq_id[$];
    int          wq_cyc[$];
    logic [1:0]  rq_id[$];
    logic [10:0] rq_words[$];
    logic [11:0] rq_h[$];
    logic [11:0] rq_v[$];
    logic [25:0] rq_steps[$];
    int          rq_cyc[$];

    always @(negedge clk) begin
        if (tb_wr_en) begin
            wq_data.push_back(tb_wr_data); wq_addr.push_back(tb_wr_addr);
            wq_id.push_back(tb_wr_id);     wq_cyc.push_back(cyc);
        end
        if (res_valid) begin
            rq_id.push_back(res_id);       rq_words.push_back(res_num_words);
            rq_h.push_back(res_H_offset);  rq_v.push_back(res_V_offset);
            rq_steps.push_back(res_num_tb_steps); rq_cyc.push_back(cyc);
        end
    end

    logic [1:0]  dseq [64];
    int          dlen;
    logic [3:0]  obs_gnt;
    logic        obs_start;
    logic [11:0] obs_ref;
    logic [19:0] obs_addr;
    logic [5:0]  obs_pe;
    int          done_cyc;
    int          last_dir_cyc;

    task automatic clear_q();
        wq_data.delete(); wq_addr.delete(); wq_id.delete(); wq_cyc.delete();
        rq_id.delete(); rq_words.delete(); rq_h.delete(); rq_v.delete();
        rq_steps.delete(); rq_cyc.delete();
    endtask

    // Runs one job from an idle arbiter: request, grant, start, dseq[0..dlen-1], done.
    task automatic drive_job(input logic [3:0] rq, input bit same);
        clear_q();
        @(negedge clk); req = rq;
        @(negedge clk); obs_gnt = gnt; req = '0;
        @(negedge clk);
        obs_start = bt_start; obs_ref = bt_ref_length; obs_addr = bt_max_score_addr; obs_pe = bt_max_score_pe;
        @(negedge clk);
        for (int i = 0; i < dlen; i++) begin
            bt_dir = dseq[i]; bt_dir_valid = 1'b1;
            if (same && i == dlen - 1) bt_done = 1'b1;
            last_dir_cyc = cyc; done_cyc = cyc;
            @(negedge clk);
        end
        bt_dir_valid = 1'b0; bt_dir = '0;
        if (!same) begin
            bt_done = 1'b1; done_cyc = cyc;
            @(negedge clk);
        end
        bt_done = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL rst_gnt got %b exp 0000", gnt); end
        checks++; if (bt_start !== 1'b0) begin errors++; $display("FAIL rst_bt_start got %b exp 0", bt_start); end
        checks++; if (tb_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got %b exp 0", tb_wr_en); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid got %b exp 0", res_valid); end
        checks++; if (bt_ref_length !== 12'h0) begin errors++; $display("FAIL rst_bt_ref got %h exp 0", bt_ref_length); end
        checks++; if (res_num_words !== 11'h0) begin errors++; $display("FAIL rst_words got %0d exp 0", res_num_words); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_single();
        dseq[0] = DIR_M; dseq[1] = DIR_M; dseq[2] = DIR_V; dseq[3] = DIR_H; dseq[4] = DIR_M; dlen = 5;
        drive_job(4'b0010, 1'b0);
        checks++; if (obs_gnt !== 4'b0010) begin errors++; $display("FAIL single_gnt got %b exp 0010", obs_gnt); end
        checks++; if (obs_start !== 1'b1) begin errors++; $display("FAIL single_start got %b exp 1", obs_start); end
        checks++; if (obs_ref !== 12'h123) begin errors++; $display("FAIL single_bt_ref got %h exp 123", obs_ref); end
        checks++; if (obs_addr !== 20'h45678) begin errors++; $display("FAIL single_bt_addr got %h exp 45678", obs_addr); end
        checks++; if (obs_pe !== 6'd37) begin errors++; $display("FAIL single_bt_pe got %0d exp 37", obs_pe); end
        checks++;
        if (wq_data.size() != 1) begin errors++; $display("FAIL single_nwr got %0d exp 1", wq_data.size()); end
        else begin
            checks++; if (wq_data[0] !== 32'h0000039F) begin errors++; $display("FAIL single_data got %h exp 0000039f", wq_data[0]); end
            checks++; if (wq_addr[0] !== 10'd0) begin errors++; $display("FAIL single_addr got %0d exp 0", wq_addr[0]); end
            checks++; if (wq_id[0] !== 2'd1) begin errors++; $display("FAIL single_wr_id got %0d exp 1", wq_id[0]); end
        end
        checks++;
        if (rq_id.size() != 1) begin errors++; $display("FAIL single_nres got %0d exp 1", rq_id.size()); end
        else begin
            checks++; if (rq_id[0] !== 2'd1) begin errors++; $display("FAIL single_res_id got %0d exp 1", rq_id[0]); end
            checks++; if (rq_words[0] !== 11'd1) begin errors++; $display("FAIL single_words got %0d exp 1", rq_words[0]); end
            checks++; if (rq_h[0] !== 12'h055 || rq_v[0] !== 12'h066) begin errors++; $display("FAIL single_offs got %h/%h exp 055/066", rq_h[0], rq_v[0]); end
            checks++; if (rq_steps[0] !== 26'd5) begin errors++; $display("FAIL single_steps got %0d exp 5", rq_steps[0]); end
            checks++; if (rq_cyc[0] - done_cyc !== 2) begin errors++; $display("FAIL single_res_lat got %0d exp 2", rq_cyc[0] - done_cyc); end
        end
    endtask

    task automatic test_exact_fill();
        for (int i = 0; i < 16; i++) dseq[i] = DIR_M;
        dlen = 16;
        drive_job(4'b0100, 1'b0);
        checks++; if (obs_gnt !== 4'b0100) begin errors++; $display("FAIL fill_gnt got %b exp 0100", obs_gnt); end
        checks++;
        if (wq_data.size() != 1) begin errors++; $display("FAIL fill_nwr got %0d exp 1", wq_data.size()); end
        else begin
            checks++; if (wq_data[0] !== 32'hFFFFFFFF) begin errors++; $display("FAIL fill_data got %h exp ffffffff", wq_data[0]); end
            checks++; if (wq_cyc[0] - last_dir_cyc !== 1) begin errors++; $display("FAIL fill_wr_lat got %0d exp 1", wq_cyc[0] - last_dir_cyc); end
        end
        checks++;
        if (rq_words.size() != 1) begin errors++; $display("FAIL fill_nres got %0d exp 1", rq_words.size()); end
        else if (rq_words[0] !== 11'd1) begin errors++; $display("FAIL fill_words got %0d exp 1", rq_words[0]); end
    endtask

    task automatic test_two_words();
        for (int i = 0; i < 16; i++) dseq[i] = 2'(i % 4);
        dseq[16] = DIR_H; dlen = 17;
        drive_job(4'b1000, 1'b0);
        checks++;
        if (wq_data.size() != 2) begin errors++; $display("FAIL two_nwr got %0d exp 2", wq_data.size()); end
        else begin
            checks++; if (wq_data[0] !== 32'hE4E4E4E4 || wq_addr[0] !== 10'd0) begin errors++; $display("FAIL two_w0 got %h@%0d exp e4e4e4e4@0", wq_data[0], wq_addr[0]); end
            checks++; if (wq_data[1] !== 32'h00000002 || wq_addr[1] !== 10'd1) begin errors++; $display("FAIL two_w1 got %h@%0d exp 00000002@1", wq_data[1], wq_addr[1]); end
            checks++; if (wq_id[1] !== 2'd3) begin errors++; $display("FAIL two_wr_id got %0d exp 3", wq_id[1]); end
        end
        checks++;
        if (rq_words.size() != 1) begin errors++; $display("FAIL two_nres got %0d exp 1", rq_words.size()); end
        else if (rq_words[0] !== 11'd2) begin errors++; $display("FAIL two_words got %0d exp 2", rq_words[0]); end
    endtask

    task automatic test_back_to_back_done();
        for (int i = 0; i < 16; i++) dseq[i] = DIR_H;
        dlen = 16;
        drive_job(4'b0001, 1'b1);
        checks++;
        if (wq_data.size() != 1) begin errors++; $display("FAIL same_nwr got %0d exp 1", wq_data.size()); end
        else if (wq_data[0] !== 32'hAAAAAAAA) begin errors++; $display("FAIL same_data got %h exp aaaaaaaa", wq_data[0]); end
        checks++;
        if (rq_words.size() != 1) begin errors++; $display("FAIL same_nres got %0d exp 1", rq_words.size()); end
        else if (rq_words[0] !== 11'd1) begin errors++; $display("FAIL same_words got %0d exp 1", rq_words[0]); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        pulse_reset();
        dlen = 0;
        for (int k = 0; k < 5; k++) begin
            drive_job(4'b1111, 1'b0);
            exp_g = 4'b0001 << (k % 4);
            checks++; if (obs_gnt !== exp_g) begin errors++; $display("FAIL rr_gnt%0d got %b exp %b", k, obs_gnt, exp_g); end
        end
        drive_job(4'b0010, 1'b0);
        checks++; if (obs_gnt !== 4'b0010) begin errors++; $display("FAIL rr_single got %b exp 0010", obs_gnt); end
        drive_job(4'b0011, 1'b0);
        checks++; if (obs_gnt !== 4'b0001) begin errors++; $display("FAIL rr_wrap got %b exp 0001", obs_gnt); end
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        dlen = 0;
        drive_job(4'b0001, 1'b0);
        clear_q();
        @(negedge clk); req = 4'b0100;
        @(negedge clk); req = '0;
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); bt_dir = DIR_M; bt_dir_valid = 1'b1;
        end
        @(negedge clk); bt_dir_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++; if (gnt !== 4'b0 || bt_start !== 1'b0) begin errors++; $display("FAIL mid_ctl got gnt=%b start=%b exp 0", gnt, bt_start); end
        checks++; if (tb_wr_en !== 1'b0 || res_valid !== 1'b0) begin errors++; $display("FAIL mid_strobes got wr=%b res=%b exp 0", tb_wr_en, res_valid); end
        checks++; if (bt_ref_length !== 12'h0 || bt_max_H_offset !== 12'h0) begin errors++; $display("FAIL mid_params got %h/%h exp 0", bt_ref_length, bt_max_H_offset); end
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (wq_data.size() != 0 || rq_id.size() != 0) begin errors++; $display("FAIL mid_leak got wr=%0d res=%0d exp 0", wq_data.size(), rq_id.size()); end
        dseq[0] = DIR_H; dlen = 1;
        drive_job(4'b1111, 1'b0);
        checks++; if (obs_gnt !== 4'b0001) begin errors++; $display("FAIL mid_rrptr got %b exp 0001", obs_gnt); end
        checks++;
        if (wq_data.size() != 1) begin errors++; $display("FAIL mid_nwr got %0d exp 1", wq_data.size()); end
        else if (wq_data[0] !== 32'h00000002 || wq_addr[0] !== 10'd0) begin errors++; $display("FAIL mid_data got %h@%0d exp 00000002@0", wq_data[0], wq_addr[0]); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_exact_fill();
        test_two_words();
        test_back_to_back_done();
        test_round_robin();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
